// File: rtl/bcm_pkg.sv
// Shared types and constants for the HUB75 64x16 (1/8 scan) BCM scan path.
package bcm_pkg;

  localparam int unsigned ROWS        = 8;
  localparam int unsigned PLANES      = 8;
  localparam int unsigned ROW_W       = 3;
  localparam int unsigned PLANE_W     = 3;
  localparam int unsigned ADDR_W      = 8;
  // Lower half-panel rows live 8 entries above the upper-half rows.
  localparam int unsigned HALF_OFFSET = 8;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StShiftReq,
    StShiftWait,
    StBlank,
    StLatch,
    StDisplay,
    StAdvance
  } state_e;

  // Colour ROM address layout: {buffer, plane, half (0 = upper), row}.
  function automatic logic [ADDR_W-1:0] rom_addr(input logic               buf_sel,
                                                 input logic [PLANE_W-1:0] plane,
                                                 input logic [ROW_W-1:0]   row);
    return {buf_sel, plane, 1'b0, row};
  endfunction

endpackage

// File: rtl/bcm_scan_scheduler_if.sv
// Scheduler <-> ROM / column shifter / panel pin bundle.
interface bcm_scan_scheduler_if;

  logic                          enable;
  logic                          shift_start;
  logic                          shift_done;
  logic [bcm_pkg::ADDR_W-1:0]    rd_addr_upper;
  logic [bcm_pkg::ADDR_W-1:0]    rd_addr_lower;
  logic [bcm_pkg::ROW_W-1:0]     row_addr;
  logic                          lat;
  logic                          oe_n;
  logic [bcm_pkg::PLANE_W-1:0]   plane;
  logic                          swap_req;
  logic                          swap_ack;
  logic                          frame_done;
  logic                          busy;

  // Scheduler side.
  modport master (
    input  enable, shift_done, swap_req,
    output shift_start, rd_addr_upper, rd_addr_lower, row_addr, lat, oe_n, plane,
           swap_ack, frame_done, busy
  );

  // Environment side (shifter, ROMs, panel, frame-buffer controller).
  modport slave (
    output enable, shift_done, swap_req,
    input  shift_start, rd_addr_upper, rd_addr_lower, row_addr, lat, oe_n, plane,
           swap_ack, frame_done, busy
  );

endinterface

// File: rtl/bcm_interval_timer.sv
// Loadable down-counter shared by every timed wait of the scan scheduler.
// Loading N gives N+1 cycles in the waiting state before expired is seen.
module bcm_interval_timer #(
  parameter int unsigned DISP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DISP_W-1:0] value,
  output logic              expired
);

  logic [DISP_W-1:0] count_q;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/bcm_scan_scheduler.sv
// BCM scan sequencer: walks bitplane (outer) and row (inner), drives the
// double-buffered ROM addresses, handshakes each row with the column shifter
// and generates blanking, LAT and a binary-weighted OE window per plane.
module bcm_scan_scheduler
  import bcm_pkg::*;
#(
  parameter int unsigned ROM_LAT    = 2,
  parameter int unsigned DEAD_TICKS = 2,
  parameter int unsigned LAT_CYCLES = 1,
  parameter int unsigned BASE_TICKS = 8,
  parameter int unsigned DISP_W     = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  bcm_scan_scheduler_if.master bus
);

  // Configuration sanity: every timed wait needs at least one cycle, and the
  // longest display window must fit the timer.
  if ((longint'(BASE_TICKS) << (PLANES - 1)) > ((longint'(1) << DISP_W) - 1)) begin : g_disp_w_chk
    $error("DISP_W too narrow for BASE_TICKS << (PLANES-1)");
  end
  if (ROM_LAT == 0 || DEAD_TICKS == 0 || LAT_CYCLES == 0 || BASE_TICKS == 0) begin : g_zero_chk
    $error("ROM_LAT, DEAD_TICKS, LAT_CYCLES and BASE_TICKS must be non-zero");
  end

  state_e               state_q;
  logic [ROW_W-1:0]     scan_row_q;
  logic [PLANE_W-1:0]   plane_q;
  logic                 buf_sel_q;
  logic [ROW_W-1:0]     row_addr_q;
  logic                 lat_q;
  logic                 oe_n_q;
  logic                 shift_start_q;
  logic                 swap_ack_q;
  logic                 frame_done_q;
  logic                 busy_q;

  logic                 tmr_load;
  logic [DISP_W-1:0]    tmr_value;
  logic                 tmr_expired;
  logic [DISP_W-1:0]    disp_len;
  logic [ADDR_W-1:0]    addr_upper;
  logic                 last_row;
  logic                 last_plane;

  assign disp_len   = DISP_W'(BASE_TICKS) << plane_q;
  assign last_row   = (scan_row_q == ROW_W'(ROWS - 1));
  assign last_plane = (plane_q == PLANE_W'(PLANES - 1));

  bcm_interval_timer #(
    .DISP_W (DISP_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  // Arm the timer on the same edge that enters a timed state.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state_q)
      StIdle, StAdvance: begin
        if (bus.enable) begin
          tmr_load  = 1'b1;
          tmr_value = DISP_W'(ROM_LAT - 1);
        end
      end
      StShiftWait: begin
        if (bus.shift_done) begin
          tmr_load  = 1'b1;
          tmr_value = DISP_W'(DEAD_TICKS - 1);
        end
      end
      StBlank: begin
        if (tmr_expired) begin
          tmr_load  = 1'b1;
          tmr_value = DISP_W'(LAT_CYCLES - 1);
        end
      end
      StLatch: begin
        if (tmr_expired) begin
          tmr_load  = 1'b1;
          tmr_value = disp_len - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Scan FSM with registered panel/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      scan_row_q    <= '0;
      plane_q       <= '0;
      buf_sel_q     <= 1'b0;
      row_addr_q    <= '0;
      lat_q         <= 1'b0;
      oe_n_q        <= 1'b1;
      shift_start_q <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      shift_start_q <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          oe_n_q <= 1'b1;
          if (bus.enable) begin
            state_q <= StFetch;
            busy_q  <= 1'b1;
          end
        end
        StFetch: begin
          if (tmr_expired) begin
            state_q       <= StShiftReq;
            shift_start_q <= 1'b1;
          end
        end
        StShiftReq: begin
          state_q <= StShiftWait;
        end
        StShiftWait: begin
          // Row pins move at the start of blanking, with OE already high.
          if (bus.shift_done) begin
            state_q    <= StBlank;
            row_addr_q <= scan_row_q;
          end
        end
        StBlank: begin
          if (tmr_expired) begin
            state_q <= StLatch;
            lat_q   <= 1'b1;
          end
        end
        StLatch: begin
          if (tmr_expired) begin
            state_q <= StDisplay;
            lat_q   <= 1'b0;
            oe_n_q  <= 1'b0;
          end
        end
        StDisplay: begin
          // Counters and pulses land together so they are visible during ADVANCE.
          if (tmr_expired) begin
            state_q <= StAdvance;
            oe_n_q  <= 1'b1;
            if (last_row) begin
              scan_row_q <= '0;
              if (last_plane) begin
                plane_q      <= '0;
                frame_done_q <= 1'b1;
                // Buffer swap only at the frame boundary.
                if (bus.swap_req) begin
                  buf_sel_q  <= ~buf_sel_q;
                  swap_ack_q <= 1'b1;
                end
              end else begin
                plane_q <= plane_q + 1'b1;
              end
            end else begin
              scan_row_q <= scan_row_q + 1'b1;
            end
          end
        end
        StAdvance: begin
          if (bus.enable) begin
            state_q <= StFetch;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign addr_upper        = rom_addr(buf_sel_q, plane_q, scan_row_q);
  assign bus.rd_addr_upper = addr_upper;
  assign bus.rd_addr_lower = addr_upper + ADDR_W'(HALF_OFFSET);
  assign bus.row_addr      = row_addr_q;
  assign bus.lat           = lat_q;
  assign bus.oe_n          = oe_n_q;
  assign bus.plane         = plane_q;
  assign bus.shift_start   = shift_start_q;
  assign bus.swap_ack      = swap_ack_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_bcm_scan_scheduler.sv
// Scoreboard bench for bcm_scan_scheduler: the driver queues expected ROM
// addresses, OE widths and frame/swap events; a monitor checks them as the
// DUT produces shift_start, OE windows and frame_done.
module tb_bcm_scan_scheduler;
  import bcm_pkg::*;

  localparam int BASE        = 4;
  localparam int DONE_DELAY  = 10;
  localparam int LAT_GAP     = 3;   // DEAD_TICKS + 1
  localparam int START_LAT   = 3;   // IDLE + ROM_LAT
  localparam int FRAME_LIMIT = 15000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_addr_q[$];
  int         exp_oe_q[$];
  logic       exp_swap_q[$];

  int n_starts = 0;
  int n_frames = 0;
  int done_cyc = 0;
  bit spurious = 1'b0;

  bcm_scan_scheduler_if bus_if ();

  bcm_scan_scheduler #(
    .ROM_LAT    (2),
    .DEAD_TICKS (2),
    .LAT_CYCLES (1),
    .BASE_TICKS (BASE),
    .DISP_W     (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected stream for one whole frame: address = buf*128 + plane*16 + row.
  task automatic push_frame(input int buf_sel, input logic swap);
    for (int p = 0; p < PLANES; p++) begin
      for (int r = 0; r < ROWS; r++) begin
        exp_addr_q.push_back(8'(buf_sel * 128 + p * 16 + r));
        exp_oe_q.push_back(BASE << p);
      end
    end
    exp_swap_q.push_back(swap);
  endtask

  // Column shifter model: shift_done 10 cycles after shift_start, optional
  // spurious pulses in BLANK and DISPLAY.
  initial begin : shifter
    int cnt;
    cnt = -1;
    bus_if.shift_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_if.shift_done = 1'b0;
      if (!rst_n) begin
        cnt = -1;
      end else if (bus_if.shift_start) begin
        cnt = DONE_DELAY;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus_if.shift_done = 1'b1;
          done_cyc = cyc;
          cnt = -1;
        end
      end else if (spurious && (cyc == done_cyc + 1 || !bus_if.oe_n)) begin
        bus_if.shift_done = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  logic       prev_lat  = 1'b0;
  logic       prev_oe_n = 1'b1;
  logic [2:0] prev_row  = '0;
  int         oe_cnt    = 0;
  logic [7:0] mon_addr;
  int         mon_w;
  logic       mon_s;

  always @(negedge clk) begin
    if (!rst_n) begin
      oe_cnt    = 0;
      prev_lat  = 1'b0;
      prev_oe_n = 1'b1;
      prev_row  = '0;
    end else begin
      if (bus_if.shift_start) begin
        n_starts++;
        if (exp_addr_q.size() == 0) begin
          check("shift_start_expected", exp_addr_q.size(), 1);
        end else begin
          mon_addr = exp_addr_q.pop_front();
          check("rd_addr_upper", bus_if.rd_addr_upper, mon_addr);
          check("rd_addr_lower", bus_if.rd_addr_lower, mon_addr + 8'd8);
        end
      end
      if (!bus_if.oe_n) begin
        oe_cnt++;
      end else if (oe_cnt != 0) begin
        if (exp_oe_q.size() == 0) begin
          check("oe_window_expected", exp_oe_q.size(), 1);
        end else begin
          mon_w = exp_oe_q.pop_front();
          check("oe_width", oe_cnt, mon_w);
        end
        oe_cnt = 0;
      end
      check("oe_low_with_lat", bus_if.lat & ~bus_if.oe_n, 0);
      if (!bus_if.oe_n && !prev_oe_n) check("row_addr_stable", bus_if.row_addr, prev_row);
      if (bus_if.lat && !prev_lat) check("lat_gap", cyc - done_cyc, LAT_GAP);
      if (bus_if.frame_done) begin
        n_frames++;
        if (exp_swap_q.size() == 0) begin
          check("frame_done_expected", exp_swap_q.size(), 1);
        end else begin
          mon_s = exp_swap_q.pop_front();
          check("swap_ack_at_frame_done", bus_if.swap_ack, mon_s);
        end
      end
      if (bus_if.swap_ack && !bus_if.frame_done) check("swap_ack_alone", bus_if.frame_done, 1);
      prev_lat  = bus_if.lat;
      prev_oe_n = bus_if.oe_n;
      prev_row  = bus_if.row_addr;
    end
  end

  initial begin : driver
    int t;
    int rel;
    int saved;
    bus_if.enable   = 1'b0;
    bus_if.swap_req = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_oe_n", bus_if.oe_n, 1);
    check("rst_lat", bus_if.lat, 0);
    check("rst_shift_start", bus_if.shift_start, 0);
    check("rst_row_addr", bus_if.row_addr, 0);
    check("rst_plane", bus_if.plane, 0);
    check("rst_swap_ack", bus_if.swap_ack, 0);
    check("rst_frame_done", bus_if.frame_done, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_rd_addr_upper", bus_if.rd_addr_upper, 0);
    check("rst_rd_addr_lower", bus_if.rd_addr_lower, 8);

    // Frame 1 plain, frame 2 with enable drop and swap, then first row of buffer 1.
    push_frame(0, 1'b0);
    push_frame(0, 1'b1);
    exp_addr_q.push_back(8'd128);
    exp_oe_q.push_back(BASE);

    @(posedge clk);
    #1;
    bus_if.enable = 1'b1;
    rst_n = 1'b1;
    rel = cyc;
    t = 0;
    while (!bus_if.shift_start && t < 50) begin @(negedge clk); t++; end
    check("first_start_latency", cyc - rel, START_LAT);

    t = 0;
    while (n_frames < 1 && t < FRAME_LIMIT) begin @(negedge clk); t++; end
    check("frame1_done_count", n_frames, 1);
    check("frame1_shift_starts", n_starts, 64);

    // Enable drop during DISPLAY of plane 2, row 5.
    t = 0;
    while (!(bus_if.plane == 3'd2 && bus_if.row_addr == 3'd5 && !bus_if.oe_n) && t < FRAME_LIMIT)
    begin @(negedge clk); t++; end
    check("reach_p2_r5_display", t < FRAME_LIMIT, 1);
    bus_if.enable = 1'b0;
    t = 0;
    while (bus_if.busy && t < 100) begin @(negedge clk); t++; end
    check("drop_busy", bus_if.busy, 0);
    check("drop_oe_n", bus_if.oe_n, 1);
    check("drop_lat", bus_if.lat, 0);
    check("drop_resume_addr", bus_if.rd_addr_upper, 38);
    saved = n_starts;
    repeat (20) @(negedge clk);
    check("idle_no_start", n_starts, saved);
    check("idle_busy", bus_if.busy, 0);
    bus_if.enable = 1'b1;

    // Swap request mid-plane 3; taken only at the frame boundary.
    t = 0;
    while (!(bus_if.plane == 3'd3 && bus_if.row_addr == 3'd3 && !bus_if.oe_n) && t < FRAME_LIMIT)
    begin @(negedge clk); t++; end
    check("reach_p3_r3_display", t < FRAME_LIMIT, 1);
    bus_if.swap_req = 1'b1;
    t = 0;
    while (n_frames < 2 && t < FRAME_LIMIT) begin @(negedge clk); t++; end
    check("frame2_done_count", n_frames, 2);
    check("frame2_shift_starts", n_starts, 128);
    bus_if.swap_req = 1'b0;
    check("swapped_addr", bus_if.rd_addr_upper, 128);

    // Asynchronous reset mid-DISPLAY, between clock edges.
    t = 0;
    while (bus_if.oe_n && t < 200) begin @(negedge clk); t++; end
    check("reach_frame3_display", bus_if.oe_n, 0);
    check("frame3_addr_consumed", exp_addr_q.size(), 0);
    #2;
    rst_n = 1'b0;
    exp_addr_q.delete();
    exp_oe_q.delete();
    exp_swap_q.delete();
    #1;
    check("arst_oe_n", bus_if.oe_n, 1);
    check("arst_lat", bus_if.lat, 0);
    check("arst_busy", bus_if.busy, 0);
    check("arst_row_addr", bus_if.row_addr, 0);
    check("arst_plane", bus_if.plane, 0);
    check("arst_rd_addr_upper", bus_if.rd_addr_upper, 0);
    check("arst_rd_addr_lower", bus_if.rd_addr_lower, 8);
    check("arst_shift_start", bus_if.shift_start, 0);
    check("arst_frame_done", bus_if.frame_done, 0);

    // Spurious shift_done in BLANK/DISPLAY: same sequence as the first rows.
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      exp_addr_q.push_back(8'(r));
      exp_oe_q.push_back(BASE);
    end
    saved = n_starts;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel = cyc;
    t = 0;
    while (!bus_if.shift_start && t < 50) begin @(negedge clk); t++; end
    check("spur_first_start_latency", cyc - rel, START_LAT);
    t = 0;
    while (exp_addr_q.size() != 0 && t < 400) begin @(negedge clk); t++; end
    check("spur_addrs_consumed", exp_addr_q.size(), 0);
    bus_if.enable = 1'b0;
    t = 0;
    while (bus_if.busy && t < 400) begin @(negedge clk); t++; end
    check("spur_busy", bus_if.busy, 0);
    check("spur_oe_windows_done", exp_oe_q.size(), 0);
    check("spur_shift_starts", n_starts - saved, 3);
    check("spur_row_addr", bus_if.row_addr, 2);
    check("spur_next_addr", bus_if.rd_addr_upper, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
